// File: rtl/adder_pkg.sv
// Shared definitions for the adder tail: FSM state encoding and a saturating add helper.
package adder_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // sat_add works on a fixed wide word so any accumulator width below SAT_MAX_W can use it.
    localparam int unsigned SAT_MAX_W = 128;
    typedef logic [SAT_MAX_W-1:0] sat_word_t;

    // Returns {overflow, result}; result is clamped to width ones when a+b does not fit.
    function automatic logic [SAT_MAX_W:0] sat_add(
        input sat_word_t   a,
        input sat_word_t   b,
        input int unsigned width
    );
        logic [SAT_MAX_W:0] full;
        sat_word_t          limit;
        full  = {1'b0, a} + {1'b0, b};
        limit = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
        if (full > {1'b0, limit}) begin
            return {1'b1, limit};
        end
        return full;
    endfunction

endpackage

// File: rtl/accum_sat_reg.sv
// Saturating accumulator register with a per-block sticky overflow flag.
module accum_sat_reg
    import adder_pkg::*;
#(
    parameter int ACCWIDTH = 40,
    parameter int DATAW    = 33
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iClr,
    input  logic                iAdd,
    input  logic                iRestart,
    input  logic [DATAW-1:0]    iData,
    output logic [ACCWIDTH-1:0] oSum,
    output logic                oOvf
);

    logic [ACCWIDTH-1:0] acc;
    logic                sticky;
    sat_word_t           acc_w;
    sat_word_t           data_w;
    logic [SAT_MAX_W:0]  result;
    logic                sat_unused;

    always_comb begin
        acc_w                 = '0;
        acc_w[ACCWIDTH-1:0]   = acc;
        data_w                = '0;
        data_w[DATAW-1:0]     = iData;
        result                = sat_add(acc_w, data_w, 32'(ACCWIDTH));
    end

    // oSum/oOvf are what the accumulator would become if this cycle's data were added.
    assign oSum       = result[ACCWIDTH-1:0];
    assign oOvf       = sticky | result[SAT_MAX_W];
    assign sat_unused = ^result[SAT_MAX_W-1:ACCWIDTH];

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            acc    <= '0;
            sticky <= 1'b0;
        end else if (iClr || iRestart) begin
            acc    <= '0;
            sticky <= 1'b0;
        end else if (iAdd) begin
            acc    <= oSum;
            sticky <= oOvf;
        end
    end

endmodule

// File: rtl/adder_accum.sv
// Reduction tail: sums DEPTH consecutive adder outputs and emits one saturated block total.
module adder_accum
    import adder_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int ACCWIDTH = BITWIDTH + 8,
    parameter int DEPTH    = 16
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iValid,
    output logic                oReady,
    input  logic [BITWIDTH:0]   iData,
    output logic                oValid,
    input  logic                iReady,
    output logic [ACCWIDTH-1:0] oData,
    output logic                oOverflow,
    output logic                oState
);

    // Handshakes: a word moves on a rising edge where its valid and ready are both high;
    // the source holds valid and data stable until then, and ready never waits on valid.

    localparam int              CNT_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic                valid_nx;
    logic                ovf_nx;
    logic                load_out;
    logic                accept;
    logic                acc_add;
    logic                acc_restart;
    logic [ACCWIDTH-1:0] sum;
    logic                sum_ovf;

    accum_sat_reg #(
        .ACCWIDTH (ACCWIDTH),
        .DATAW    (BITWIDTH + 1)
    ) u_acc (
        .iClk     (iClk),
        .iRstN    (iRstN),
        .iClr     (iClr),
        .iAdd     (acc_add),
        .iRestart (acc_restart),
        .iData    (iData),
        .oSum     (sum),
        .oOvf     (sum_ovf)
    );

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        valid_nx    = oValid;
        ovf_nx      = oOverflow;
        oReady      = 1'b0;
        accept      = 1'b0;
        acc_add     = 1'b0;
        acc_restart = 1'b0;
        load_out    = 1'b0;

        case (state)
            ST_ACC:  oReady = iEn;
            default: oReady = 1'b0;
        endcase

        // A word presented during a clear is dropped even though oReady may be high.
        accept = iValid & oReady & ~iClr;

        if (iClr) begin
            state_nx = ST_ACC;
            cnt_nx   = '0;
            valid_nx = 1'b0;
            ovf_nx   = 1'b0;
        end else if (state == ST_HOLD) begin
            if (iReady) begin
                state_nx = ST_ACC;
                valid_nx = 1'b0;
            end
        end else if (accept) begin
            if (cnt == CNT_LAST) begin
                acc_restart = 1'b1;
                load_out    = 1'b1;
                valid_nx    = 1'b1;
                ovf_nx      = sum_ovf;
                cnt_nx      = '0;
                state_nx    = ST_HOLD;
            end else begin
                acc_add = 1'b1;
                cnt_nx  = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state     <= ST_ACC;
            cnt       <= '0;
            oValid    <= 1'b0;
            oData     <= '0;
            oOverflow <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            oValid    <= valid_nx;
            oOverflow <= ovf_nx;
            if (load_out) begin
                oData <= sum;
            end
        end
    end

    assign oState = state;

endmodule

// File: tb/tb_adder_accum.sv
// Directed bench for adder_accum: two configurations checked against a block-sum model.
module tb_adder_accum;

    localparam int NDUT = 2;
    localparam int          DEPTH_OF [NDUT] = '{4, 2};
    localparam logic [63:0] MAXV     [NDUT] = '{64'hFF_FFFF_FFFF, 64'h1_FFFF_FFFF};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        en      [NDUT];
    logic        clr     [NDUT];
    logic        vin     [NDUT];
    logic        rdy_in  [NDUT];
    logic [32:0] din     [NDUT];
    logic        vout    [NDUT];
    logic        rdy_out [NDUT];
    logic        ovf_out [NDUT];
    logic        st_out  [NDUT];
    logic [39:0] q_a;
    logic [32:0] q_b;
    logic [63:0] q_out   [NDUT];

    always_comb begin
        q_out[0] = 64'(q_a);
        q_out[1] = 64'(q_b);
    end

    adder_accum #(.BITWIDTH(32), .ACCWIDTH(40), .DEPTH(4)) u_a (
        .iClk(clk), .iRstN(rst_n), .iEn(en[0]), .iClr(clr[0]), .iValid(vin[0]),
        .oReady(rdy_out[0]), .iData(din[0]), .oValid(vout[0]), .iReady(rdy_in[0]),
        .oData(q_a), .oOverflow(ovf_out[0]), .oState(st_out[0])
    );

    adder_accum #(.BITWIDTH(32), .ACCWIDTH(33), .DEPTH(2)) u_b (
        .iClk(clk), .iRstN(rst_n), .iEn(en[1]), .iClr(clr[1]), .iValid(vin[1]),
        .oReady(rdy_out[1]), .iData(din[1]), .oValid(vout[1]), .iReady(rdy_in[1]),
        .oData(q_b), .oOverflow(ovf_out[1]), .oState(st_out[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int d, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h exp=%0h at %0t", name, d, got, exp, $time);
        end
    endtask

    // Model: block total is the plain sum of DEPTH accepted words, clamped to the output range.
    logic [63:0] m_sum   [NDUT];
    logic [63:0] m_data  [NDUT];
    int          m_cnt   [NDUT];
    logic        m_valid [NDUT];
    logic        m_ovf   [NDUT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < NDUT; d++) begin
                m_sum[d] = '0; m_data[d] = '0; m_cnt[d] = 0; m_valid[d] = 1'b0; m_ovf[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < NDUT; d++) begin
                if (clr[d]) begin
                    m_sum[d] = '0; m_cnt[d] = 0; m_valid[d] = 1'b0; m_ovf[d] = 1'b0;
                end else if (m_valid[d]) begin
                    if (rdy_in[d]) m_valid[d] = 1'b0;
                end else if (en[d] && vin[d]) begin
                    m_sum[d] = m_sum[d] + 64'(din[d]);
                    m_cnt[d] = m_cnt[d] + 1;
                    if (m_cnt[d] == DEPTH_OF[d]) begin
                        m_ovf[d]   = (m_sum[d] > MAXV[d]);
                        m_data[d]  = m_ovf[d] ? MAXV[d] : m_sum[d];
                        m_valid[d] = 1'b1;
                        m_sum[d]   = '0;
                        m_cnt[d]   = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < NDUT; d++) begin
                check("oValid", d, 64'(vout[d]), 64'(m_valid[d]));
                check("oReady", d, 64'(rdy_out[d]), 64'(en[d] && !m_valid[d]));
                if (m_valid[d]) begin
                    check("oData", d, q_out[d], m_data[d]);
                    check("oOverflow", d, 64'(ovf_out[d]), 64'(m_ovf[d]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [32:0] v);
        bit done = 1'b0;
        vin[d] = 1'b1;
        din[d] = v;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (rdy_out[d] && !clr[d]) done = 1'b1;
            tick();
        end
        vin[d] = 1'b0;
        check("send_accept", d, 64'(done), 64'd1);
    endtask

    task automatic expect_block(input int d, input logic [63:0] data, input logic ovf,
                                input int max_wait);
        bit seen = 1'b0;
        for (int i = 0; i < max_wait && !seen; i++) begin
            @(negedge clk);
            if (vout[d]) seen = 1'b1;
        end
        check("block_valid", d, 64'(seen), 64'd1);
        if (seen) begin
            check("block_data", d, q_out[d], data);
            check("block_ovf", d, 64'(ovf_out[d]), 64'(ovf));
            check("model_data", d, m_data[d], data);
            check("model_ovf", d, 64'(m_ovf[d]), 64'(ovf));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            en[d] = 1'b1; clr[d] = 1'b0; vin[d] = 1'b0; rdy_in[d] = 1'b1; din[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("rst_valid", d, 64'(vout[d]), 64'd0);
            check("rst_data", d, q_out[d], 64'd0);
            check("rst_ovf", d, 64'(ovf_out[d]), 64'd0);
            check("rst_ready", d, 64'(rdy_out[d]), 64'd1);
            check("rst_state", d, 64'(st_out[d]), 64'd0);
        end
        tick();

        // Back-to-back block, result visible one cycle after the last accept.
        send(0, 33'd1); send(0, 33'd2); send(0, 33'd3); send(0, 33'd4);
        expect_block(0, 64'd10, 1'b0, 1);
        tick();

        // Downstream stall: result held, then one bubble after release.
        rdy_in[0] = 1'b0;
        send(0, 33'd7); send(0, 33'd8); send(0, 33'd9); send(0, 33'd10);
        expect_block(0, 64'd34, 1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 0, 64'(vout[0]), 64'd1);
            check("hold_data", 0, q_out[0], 64'd34);
            check("hold_ready", 0, 64'(rdy_out[0]), 64'd0);
        end
        tick();
        rdy_in[0] = 1'b1;
        @(negedge clk);
        check("bubble_valid", 0, 64'(vout[0]), 64'd1);
        check("bubble_ready", 0, 64'(rdy_out[0]), 64'd0);
        @(negedge clk);
        check("release_valid", 0, 64'(vout[0]), 64'd0);
        check("release_ready", 0, 64'(rdy_out[0]), 64'd1);
        tick();

        // Clear mid-block drops the partial sum and the word offered with it.
        send(0, 33'd100); send(0, 33'd200);
        clr[0] = 1'b1; vin[0] = 1'b1; din[0] = 33'd999;
        @(negedge clk);
        check("clr_ready", 0, 64'(rdy_out[0]), 64'd1);
        tick();
        clr[0] = 1'b0; vin[0] = 1'b0;
        send(0, 33'd5); send(0, 33'd5); send(0, 33'd5); send(0, 33'd5);
        expect_block(0, 64'd20, 1'b0, 2);
        tick();

        // Stage disabled mid-block with a word waiting.
        send(0, 33'd1); send(0, 33'd1);
        en[0] = 1'b0; vin[0] = 1'b1; din[0] = 33'd50;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("en0_ready", 0, 64'(rdy_out[0]), 64'd0);
            check("en0_valid", 0, 64'(vout[0]), 64'd0);
            tick();
        end
        en[0] = 1'b1;
        send(0, 33'd50); send(0, 33'd2);
        expect_block(0, 64'd54, 1'b0, 2);
        tick();

        // Narrow accumulator: saturation, recovery, and an exact full-scale sum.
        send(1, 33'h1_FFFF_FFFF); send(1, 33'h1_FFFF_FFFF);
        expect_block(1, 64'h1_FFFF_FFFF, 1'b1, 2);
        tick();
        send(1, 33'd1); send(1, 33'd1);
        expect_block(1, 64'd2, 1'b0, 2);
        tick();
        send(1, 33'h1_0000_0000); send(1, 33'h0_FFFF_FFFF);
        expect_block(1, 64'h1_FFFF_FFFF, 1'b0, 2);
        tick();

        // Asynchronous reset while a result is held.
        rdy_in[0] = 1'b0;
        send(0, 33'd1); send(0, 33'd1); send(0, 33'd1); send(0, 33'd1);
        expect_block(0, 64'd4, 1'b0, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 0, 64'(vout[0]), 64'd0);
        check("async_data", 0, q_out[0], 64'd0);
        check("async_state", 0, 64'(st_out[0]), 64'd0);
        #1 rst_n = 1'b1;
        rdy_in[0] = 1'b1;
        tick();
        send(0, 33'd3); send(0, 33'd3); send(0, 33'd3); send(0, 33'd3);
        expect_block(0, 64'd12, 1'b0, 2);
        tick();

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
